switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Input-conditioning stage between raw Nexys A7 slide switches and the combinational
//  logic core (a, b, c). Synchronises each asynchronous switch to clk, filters contact
//  bounce with a per-channel stability counter, and presents clean levels plus
//  single-cycle rise/fall pulses. The core's a/b/c inputs connect to sw_clean[0..2].
// PARAMETERS
//  N_CH          3          number of switch channels
//  SYNC_STAGES   2          synchroniser flop depth (>=2)
//  STABLE_CYCLES 1_000_000  cycles a new level must hold before acceptance (10 ms @100 MHz; >=2)
// PORTS
//  clk       in   1     system clock, 100 MHz
//  rst_n     in   1     asynchronous active-low reset
//  sw_raw    in   N_CH  raw switch levels, asynchronous to clk
//  sw_clean  out  N_CH  debounced level per channel
//  sw_rise   out  N_CH  1-cycle pulse when sw_clean goes 0->1
//  sw_fall   out  N_CH  1-cycle pulse when sw_clean goes 1->0
//  sw_valid  out  1     high once startup settle period has elapsed; stays high until reset
// BEHAVIOUR
//  - Reset (rst_n low, async): sync flops, counters, sw_clean, sw_rise, sw_fall, sw_valid
//    all 0; every channel FSM -> S_LOW. Asserting reset mid-count aborts immediately.
//  - Sync: sw_raw[i] passes through SYNC_STAGES flops -> s[i]. No logic on raw input.
//  - Per-channel FSM (state, counter width $clog2(STABLE_CYCLES)):
//      S_LOW : s=1 -> S_RISE, cnt=0.            s=0 -> stay.
//      S_RISE: s=0 -> S_LOW, cnt=0 (bounce).    s=1 & cnt<STABLE_CYCLES-1 -> cnt++.
//              s=1 & cnt==STABLE_CYCLES-1 -> S_HIGH, sw_clean=1, rise pulse.
//      S_HIGH: s=0 -> S_FALL, cnt=0.            s=1 -> stay.
//      S_FALL: s=1 -> S_HIGH, cnt=0 (bounce).   s=0 & cnt<STABLE_CYCLES-1 -> cnt++.
//              s=0 & cnt==STABLE_CYCLES-1 -> S_LOW, sw_clean=0, fall pulse.
//  - sw_clean registered; changes on the same edge as the FSM S_RISE->S_HIGH/S_FALL->S_LOW move.
//  - Latency: raw level stable from edge k -> sw_clean updates at edge k+SYNC_STAGES+STABLE_CYCLES.
//  - Any glitch shorter than STABLE_CYCLES synced cycles produces no output change.
//  - sw_rise/sw_fall registered, high exactly one cycle, coincident with the sw_clean change;
//    never both high on one channel; channels fully independent (simultaneous events allowed).
//  - Startup: global counter counts STABLE_CYCLES+SYNC_STAGES cycles after rst_n release,
//    then sw_valid=1 (sticky). While sw_valid=0, sw_clean updates normally but sw_rise/sw_fall
//    are forced 0 (switches already on at power-up do not emit spurious edges).
//  - Counters saturate logic-wise by FSM exit; no wrap-around possible.
//  - Elaboration error if STABLE_CYCLES<2 or SYNC_STAGES<2.
// STRUCTURE
//  - debounce_pkg: typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_t;
//    function for counter width.
//  - Sub-module debounce_channel (one channel: sync chain + FSM + counter + pulse regs),
//    instantiated N_CH times via generate; top holds startup counter and pulse gating.
// TESTING  (sim params: STABLE_CYCLES=4, SYNC_STAGES=2, N_CH=3)
//  1. Reset: rst_n=0 with sw_raw=3'b111 -> all outputs 0; pull rst_n low mid S_RISE count
//     -> sw_clean stays 0, counter cleared, no pulse after release until full re-qualify.
//  2. Startup: rst_n released at edge 0, sw_raw=3'b001 static -> sw_valid=1 at edge 6,
//     sw_clean[0]=1 at edge 6, sw_rise all 0 throughout.
//  3. Clean press after valid: sw_raw[1] 0->1 sampled at edge k -> sw_clean[1]=1 and
//     sw_rise[1]=1 at edge k+6, sw_rise[1]=0 at k+7.
//  4. Bounce: sw_raw[2] toggles every 2 cycles for 20 cycles, ends at 1 -> exactly one
//     sw_rise[2] pulse, 6 cycles after last transition; no fall pulse.
//  5. Glitch: sw_raw[0] high for 3 cycles then low -> no change on any output.
//  6. Simultaneous: sw_raw 3'b011 -> 3'b100 on one edge -> at +6: sw_clean=3'b100,
//     sw_fall=3'b011, sw_rise=3'b100 in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser chain, stability-counting FSM and
// registered clean level with single-cycle edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_pulse_en,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned      CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_t              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

  // Raw input goes straight into the first flop, no logic ahead of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (w_s) begin
            r_state <= S_RISE;
            r_cnt   <= '0;
          end
        end
        S_RISE: begin
          if (!w_s) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_clean <= 1'b1;
            r_rise  <= i_pulse_en;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!w_s) begin
            r_state <= S_FALL;
            r_cnt   <= '0;
          end
        end
        S_FALL: begin
          if (w_s) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_fall  <= i_pulse_en;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_CH slide switches; holds the startup settle counter that
// suppresses edge pulses until the inputs have had time to qualify.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_clean,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            sw_valid
);

  localparam int unsigned     SETTLE  = STABLE_CYCLES + SYNC_STAGES;
  localparam int unsigned     ST_W    = cnt_width(SETTLE + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE);

  if (STABLE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_bad_param
    $error("switch_debouncer: STABLE_CYCLES and SYNC_STAGES must both be >= 2");
  end

  logic [ST_W-1:0] r_settle_cnt;
  logic            r_valid;

  assign sw_valid = r_valid;

  // Pulses are gated by the pre-edge valid, so an edge qualifying on the
  // same cycle valid rises is still treated as a power-up level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_valid      <= 1'b0;
    end else if (!r_valid) begin
      if (r_settle_cnt == ST_LAST) begin
        r_valid <= 1'b1;
      end else begin
        r_settle_cnt <= r_settle_cnt + ST_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_raw     (sw_raw[g]),
      .i_pulse_en(r_valid),
      .o_clean   (sw_clean[g]),
      .o_rise    (sw_rise[g]),
      .o_fall    (sw_fall[g])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with short settle parameters.
module tb_switch_debouncer;

  localparam int unsigned N_CH          = 3;
  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned STABLE_CYCLES = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] sw_raw;
  logic [N_CH-1:0] sw_clean;
  logic [N_CH-1:0] sw_rise;
  logic [N_CH-1:0] sw_fall;
  logic            sw_valid;

  int checks   = 0;
  int failures = 0;

  switch_debouncer #(
    .N_CH         (N_CH),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .sw_valid(sw_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N_CH-1:0] acc;
  int nr;
  int nf;
  int rise_at;

  initial begin
    rst_n  = 1'b0;
    sw_raw = 3'b111;
    repeat (3) tick();
    check("rst_clean", 32'(sw_clean), 32'h0);
    check("rst_rise",  32'(sw_rise),  32'h0);
    check("rst_fall",  32'(sw_fall),  32'h0);
    check("rst_valid", 32'(sw_valid), 32'h0);

    // Startup with channel 0 already on: qualifies with valid, no pulse.
    sw_raw = 3'b001;
    rst_n  = 1'b1;
    acc    = '0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      acc |= sw_rise | sw_fall;
      if (e == 5) begin
        check("start_valid_e5", 32'(sw_valid), 32'h0);
        check("start_clean_e5", 32'(sw_clean), 32'h0);
      end
    end
    check("start_valid_e6", 32'(sw_valid), 32'h1);
    check("start_clean_e6", 32'(sw_clean), 32'h1);
    check("start_no_pulse", 32'(acc), 32'h0);

    // Reset mid-qualification of channel 1.
    sw_raw = 3'b011;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_clean", 32'(sw_clean), 32'h0);
    check("midrst_valid", 32'(sw_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    acc   = '0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      acc |= sw_rise | sw_fall;
      if (e == 5) check("requal_clean_e5", 32'(sw_clean), 32'h0);
    end
    check("requal_clean_e6", 32'(sw_clean), 32'h3);
    check("requal_valid",    32'(sw_valid), 32'h1);
    check("requal_no_pulse", 32'(acc), 32'h0);

    // Clean press on channel 2 after valid.
    sw_raw = 3'b111;
    for (int n = 0; n <= 7; n++) begin
      tick();
      if (n == 5) check("press_clean_k5", 32'(sw_clean), 32'h3);
      if (n == 6) begin
        check("press_clean_k6", 32'(sw_clean), 32'h7);
        check("press_rise_k6",  32'(sw_rise),  32'h4);
        check("press_fall_k6",  32'(sw_fall),  32'h0);
      end
      if (n == 7) check("press_rise_k7", 32'(sw_rise), 32'h0);
    end

    // Release channel 2.
    sw_raw = 3'b011;
    for (int n = 0; n <= 7; n++) begin
      tick();
      if (n == 6) begin
        check("release_fall_k6",  32'(sw_fall),  32'h4);
        check("release_clean_k6", 32'(sw_clean), 32'h3);
      end
    end

    // Bounce on channel 2: 2-cycle segments, then settles high.
    nr = 0;
    nf = 0;
    for (int i = 0; i < 10; i++) begin
      sw_raw[2] = (i % 2 == 0);
      repeat (2) begin
        tick();
        nr += int'(sw_rise[2]);
        nf += int'(sw_fall[2]);
      end
    end
    sw_raw[2] = 1'b1;
    rise_at   = -1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (sw_rise[2]) begin
        nr++;
        rise_at = n;
      end
      nf += int'(sw_fall[2]);
    end
    check("bounce_rise_cnt", 32'(nr), 32'd1);
    check("bounce_fall_cnt", 32'(nf), 32'd0);
    check("bounce_rise_at",  32'(rise_at), 32'd6);
    check("bounce_clean",    32'(sw_clean), 32'h7);

    // Glitch of 3 cycles on channel 0 while it is low.
    sw_raw = 3'b110;
    repeat (8) tick();
    check("glitch_pre_clean", 32'(sw_clean), 32'h6);
    acc       = '0;
    sw_raw[0] = 1'b1;
    repeat (3) begin
      tick();
      acc |= sw_rise | sw_fall;
    end
    sw_raw[0] = 1'b0;
    repeat (12) begin
      tick();
      acc |= sw_rise | sw_fall;
    end
    check("glitch_no_pulse", 32'(acc), 32'h0);
    check("glitch_clean",    32'(sw_clean), 32'h6);

    // Simultaneous rise and fall on different channels.
    sw_raw = 3'b011;
    repeat (8) tick();
    check("simul_pre_clean", 32'(sw_clean), 32'h3);
    sw_raw = 3'b100;
    for (int n = 0; n <= 7; n++) begin
      tick();
      if (n == 5) begin
        check("simul_clean_k5", 32'(sw_clean), 32'h3);
        check("simul_fall_k5",  32'(sw_fall),  32'h0);
      end
      if (n == 6) begin
        check("simul_clean_k6", 32'(sw_clean), 32'h4);
        check("simul_fall_k6",  32'(sw_fall),  32'h3);
        check("simul_rise_k6",  32'(sw_rise),  32'h4);
      end
      if (n == 7) begin
        check("simul_rise_k7", 32'(sw_rise), 32'h0);
        check("simul_fall_k7", 32'(sw_fall), 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
